toggle_pulse_decoder: RTL

- Receiver end of the toggle signalling used by our T flip-flop blocks. A remote TFF flips a level once per event; this block converts each level change back into a single-cycle pulse in the local clock domain.
- Counts events and measures the cycle interval between consecutive events.
- Presents each interval through a valid/ready holding register.
- Sits between any TFF-based event source and local control/monitor logic.

---
 rtl/toggle_pulse_decoder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/toggle_pulse_decoder.sv
// Turns each level change of a remote toggle flip-flop into a one-cycle local pulse,
// counts events and measures the cycle interval between them through a valid/ready holder.
module toggle_pulse_decoder #(
    parameter int CNT_W   = 8,
    parameter int PER_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Tog,
    input  logic             in_Clear,
    input  logic             in_Ready,
    output logic             out_Pulse,
    output logic [CNT_W-1:0] out_Count,
    output logic             out_Ovf,
    output logic [PER_W-1:0] out_Period,
    output logic             out_Valid,
    output logic             out_Lost,
    output logic             out_Timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);
    localparam logic [PER_W-1:0] TIMEOUT_V = PER_W'(TIMEOUT);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [1:0]       r_warm;
    logic             r_pulse;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [PER_W-1:0] r_period;
    logic             r_valid;
    logic             r_lost;
    logic             r_timeout;
    state_t           r_state;
    logic [PER_W-1:0] r_interval;

    logic             w_edge;
    state_t           w_stateNext;
    logic [PER_W-1:0] w_intervalNext;
    logic             w_capture;
    logic             w_timeout;

    // Edges are masked until the chain has filled, so a high level at reset release is not an event.
    assign w_edge = (r_sync2 ^ r_sync3) & (r_warm == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_warm  <= 2'd0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= in_Tog;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            r_pulse <= w_edge;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (in_Clear) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_edge) begin
            if (r_count != CNT_MAX) begin
                r_count <= r_count + CNT_ONE;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_interval <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_interval <= w_intervalNext;
            r_timeout  <= w_timeout;
        end
    end

    // An edge on the timeout cycle wins: it is checked before the timeout compare.
    always_comb begin
        w_stateNext    = r_state;
        w_intervalNext = r_interval;
        w_capture      = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_stateNext    = MEASURE;
                    w_intervalNext = PER_ONE;
                end
            end
            MEASURE: begin
                if (w_edge) begin
                    w_capture      = 1'b1;
                    w_intervalNext = PER_ONE;
                end else if (r_interval == TIMEOUT_V) begin
                    w_stateNext    = IDLE;
                    w_intervalNext = '0;
                    w_timeout      = 1'b1;
                end else begin
                    w_intervalNext = r_interval + PER_ONE;
                end
            end
            default: begin
                w_stateNext    = IDLE;
                w_intervalNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
            r_valid  <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            if (w_capture && (!r_valid || in_Ready)) begin
                r_period <= r_interval;
                r_valid  <= 1'b1;
            end else if (r_valid && in_Ready) begin
                r_valid <= 1'b0;
            end
            if (in_Clear) begin
                r_lost <= 1'b0;
            end else if (w_capture && r_valid && !in_Ready) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign out_Pulse   = r_pulse;
    assign out_Count   = r_count;
    assign out_Ovf     = r_ovf;
    assign out_Period  = r_period;
    assign out_Valid   = r_valid;
    assign out_Lost    = r_lost;
    assign out_Timeout = r_timeout;

endmodule
